// File: rtl/branch_predictor_pkg.sv
// Shared types for the BTB branch predictor: counter/flush-state enums, entry layout and
// the saturating counter update.
package BranchPredictorPackage;

    // ENTRIES >= 2 means INDEX_W >= 1, so 29 bits covers any tag width.
    localparam int unsigned TAG_MAX_W = 29;

    typedef enum logic [1:0] {
        BtbCounter_StrongNT = 2'd0,
        BtbCounter_WeakNT   = 2'd1,
        BtbCounter_WeakT    = 2'd2,
        BtbCounter_StrongT  = 2'd3
    } BtbCounter;

    typedef enum logic {
        FlushState_IDLE,
        FlushState_CLEARING
    } FlushState;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
        BtbCounter            ctr;
    } BtbEntry;

    function automatic BtbCounter nextCounter(input BtbCounter ctr, input logic taken);
        BtbCounter r;
        r = ctr;
        if (taken) begin
            if (ctr != BtbCounter_StrongT) r = BtbCounter'(ctr + 2'd1);
        end else begin
            if (ctr != BtbCounter_StrongNT) r = BtbCounter'(ctr - 2'd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/resolve/flush bundle between the pipeline and branch_predictor.
// Stats signals exist only when BRANCH_PREDICTOR_STATS_EN is defined.
interface branch_predictor_if;
    logic        fetchValid;
    logic [31:0] fetchPC;
    logic        predValid;
    logic [31:0] predPC;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        resolveValid;
    logic        resolveIsBranch;
    logic [31:0] resolvePC;
    logic        resolveTaken;
    logic [31:0] resolveTarget;
    logic        resolvePredTaken;
    logic [31:0] resolvePredTarget;
    logic        flush;
    logic        flushBusy;
    logic        mispredict;
    logic [31:0] redirectPC;
`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] statBranches;
    logic [31:0] statMispredicts;

    modport master (
        output fetchValid, fetchPC, resolveValid, resolveIsBranch, resolvePC, resolveTaken,
               resolveTarget, resolvePredTaken, resolvePredTarget, flush,
        input  predValid, predPC, predTaken, predTarget, flushBusy, mispredict, redirectPC,
               statBranches, statMispredicts
    );
    modport slave (
        input  fetchValid, fetchPC, resolveValid, resolveIsBranch, resolvePC, resolveTaken,
               resolveTarget, resolvePredTaken, resolvePredTarget, flush,
        output predValid, predPC, predTaken, predTarget, flushBusy, mispredict, redirectPC,
               statBranches, statMispredicts
    );
`else
    modport master (
        output fetchValid, fetchPC, resolveValid, resolveIsBranch, resolvePC, resolveTaken,
               resolveTarget, resolvePredTaken, resolvePredTarget, flush,
        input  predValid, predPC, predTaken, predTarget, flushBusy, mispredict, redirectPC
    );
    modport slave (
        input  fetchValid, fetchPC, resolveValid, resolveIsBranch, resolvePC, resolveTaken,
               resolveTarget, resolvePredTaken, resolvePredTarget, flush,
        output predValid, predPC, predTaken, predTarget, flushBusy, mispredict, redirectPC
    );
`endif
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB storage: asynchronous fetch read, read-modify-write update port and a
// per-index clear port; reads return contents from before the same-edge write.
module branch_target_buffer
    import BranchPredictorPackage::*;
#(
    parameter int unsigned ENTRIES = 16,
    localparam int unsigned INDEX_W = $clog2(ENTRIES)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] rd_idx_i,
    output BtbEntry            rd_entry_o,
    input  logic [INDEX_W-1:0] wr_idx_i,
    output BtbEntry            wr_cur_o,
    input  logic               wr_en_i,
    input  BtbEntry            wr_entry_i,
    input  logic               clr_en_i,
    input  logic [INDEX_W-1:0] clr_idx_i
);
    localparam BtbEntry RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: BtbCounter_WeakNT};

    BtbEntry table_q [ENTRIES];

    assign rd_entry_o = table_q[rd_idx_i];
    assign wr_cur_o   = table_q[wr_idx_i];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) table_q[i] <= RESET_ENTRY;
        end else if (clr_en_i) begin
            table_q[clr_idx_i].valid <= 1'b0;
            table_q[clr_idx_i].ctr   <= BtbCounter_WeakNT;
        end else if (wr_en_i) begin
            table_q[wr_idx_i] <= wr_entry_i;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// BTB branch predictor: registered prediction, update policy, mispredict/redirect and the
// flush sequencer. Optional counters under `ifdef BRANCH_PREDICTOR_STATS_EN.
module branch_predictor
    import BranchPredictorPackage::*;
#(
    parameter int unsigned ENTRIES = 16
) (
    input logic                clk,
    input logic                rst,
    branch_predictor_if.slave  bp
);
    localparam int unsigned INDEX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W   = 30 - INDEX_W;
    localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(ENTRIES - 1);

    FlushState          state_q, state_d;
    logic [INDEX_W-1:0] clearIdx_q, clearIdx_d;

    logic        predValid_q, predValid_d, predTaken_q, predTaken_d;
    logic [31:0] predPC_q, predPC_d, predTarget_q, predTarget_d;
    logic        mispredict_q, mispredict_d;
    logic [31:0] redirectPC_q, redirectPC_d;

    logic [INDEX_W-1:0] fetch_idx, res_idx;
    logic [TAG_W-1:0]   fetch_tag, res_tag;
    BtbEntry            rd_entry, cur_entry, wr_entry;
    logic               wr_en, fetch_hit, res_hit, fetch_taken, actual_taken, mp_c, idle;

    assign idle      = (state_q == FlushState_IDLE);
    assign fetch_idx = bp.fetchPC[INDEX_W+1:2];
    assign fetch_tag = bp.fetchPC[31:INDEX_W+2];
    assign res_idx   = bp.resolvePC[INDEX_W+1:2];
    assign res_tag   = bp.resolvePC[31:INDEX_W+2];

    branch_target_buffer #(.ENTRIES(ENTRIES)) u_btb (
        .clk        (clk),
        .rst_n      (rst),
        .rd_idx_i   (fetch_idx),
        .rd_entry_o (rd_entry),
        .wr_idx_i   (res_idx),
        .wr_cur_o   (cur_entry),
        .wr_en_i    (wr_en),
        .wr_entry_i (wr_entry),
        .clr_en_i   (!idle),
        .clr_idx_i  (clearIdx_q)
    );

    // Tags are stored zero-extended, so comparing at full width is exact.
    assign fetch_hit   = rd_entry.valid && (rd_entry.tag == TAG_MAX_W'(fetch_tag));
    assign res_hit     = cur_entry.valid && (cur_entry.tag == TAG_MAX_W'(res_tag));
    assign fetch_taken = idle && fetch_hit && rd_entry.ctr[1];

    always_comb begin
        predValid_d  = bp.fetchValid;
        predPC_d     = predPC_q;
        predTaken_d  = predTaken_q;
        predTarget_d = predTarget_q;
        if (bp.fetchValid) begin
            predPC_d     = bp.fetchPC;
            predTaken_d  = fetch_taken;
            predTarget_d = fetch_taken ? rd_entry.target : bp.fetchPC + 32'd4;
        end
    end

    always_comb begin
        wr_en    = 1'b0;
        wr_entry = cur_entry;
        if (bp.resolveValid && idle) begin
            if (bp.resolveIsBranch) begin
                if (res_hit) begin
                    wr_en        = 1'b1;
                    wr_entry.ctr = nextCounter(cur_entry.ctr, bp.resolveTaken);
                    if (bp.resolveTaken) wr_entry.target = bp.resolveTarget;
                end else if (bp.resolveTaken) begin
                    wr_en           = 1'b1;
                    wr_entry.valid  = 1'b1;
                    wr_entry.tag    = TAG_MAX_W'(res_tag);
                    wr_entry.target = bp.resolveTarget;
                    wr_entry.ctr    = BtbCounter_WeakT;
                end
            end else if (res_hit) begin
                wr_en          = 1'b1;
                wr_entry.valid = 1'b0;
            end
        end
    end

    // Non-branches resolve as not-taken; mispredict is computed even while clearing.
    assign actual_taken = bp.resolveIsBranch && bp.resolveTaken;
    assign mp_c = bp.resolveValid &&
                  ((actual_taken != bp.resolvePredTaken) ||
                   (actual_taken && (bp.resolveTarget != bp.resolvePredTarget)));

    always_comb begin
        mispredict_d = mp_c;
        redirectPC_d = redirectPC_q;
        if (mp_c) redirectPC_d = actual_taken ? bp.resolveTarget : bp.resolvePC + 32'd4;
    end

    always_comb begin
        state_d    = state_q;
        clearIdx_d = clearIdx_q;
        case (state_q)
            FlushState_IDLE: begin
                if (bp.flush) begin
                    state_d    = FlushState_CLEARING;
                    clearIdx_d = '0;
                end
            end
            FlushState_CLEARING: begin
                if (bp.flush) begin
                    clearIdx_d = '0;
                end else if (clearIdx_q == LAST_IDX) begin
                    state_d    = FlushState_IDLE;
                    clearIdx_d = '0;
                end else begin
                    clearIdx_d = clearIdx_q + INDEX_W'(1);
                end
            end
            default: begin
                state_d    = FlushState_IDLE;
                clearIdx_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= FlushState_IDLE;
            clearIdx_q   <= '0;
            predValid_q  <= 1'b0;
            predPC_q     <= '0;
            predTaken_q  <= 1'b0;
            predTarget_q <= '0;
            mispredict_q <= 1'b0;
            redirectPC_q <= '0;
        end else begin
            state_q      <= state_d;
            clearIdx_q   <= clearIdx_d;
            predValid_q  <= predValid_d;
            predPC_q     <= predPC_d;
            predTaken_q  <= predTaken_d;
            predTarget_q <= predTarget_d;
            mispredict_q <= mispredict_d;
            redirectPC_q <= redirectPC_d;
        end
    end

    assign bp.predValid  = predValid_q;
    assign bp.predPC     = predPC_q;
    assign bp.predTaken  = predTaken_q;
    assign bp.predTarget = predTarget_q;
    assign bp.mispredict = mispredict_q;
    assign bp.redirectPC = redirectPC_q;
    assign bp.flushBusy  = !idle;

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] statBranches_q, statBranches_d, statMispredicts_q, statMispredicts_d;

    always_comb begin
        statBranches_d    = statBranches_q;
        statMispredicts_d = statMispredicts_q;
        if (bp.resolveValid && bp.resolveIsBranch) statBranches_d = statBranches_q + 32'd1;
        if (mp_c) statMispredicts_d = statMispredicts_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            statBranches_q    <= '0;
            statMispredicts_q <= '0;
        end else begin
            statBranches_q    <= statBranches_d;
            statMispredicts_q <= statMispredicts_d;
        end
    end

    assign bp.statBranches    = statBranches_q;
    assign bp.statMispredicts = statMispredicts_q;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized traffic
// checked against a table-level reference model.
module tb_branch_predictor;
    localparam int unsigned N  = 16;
    localparam int unsigned IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int unsigned checks = 0;
    int unsigned failures = 0;

    branch_predictor_if bus ();

    branch_predictor #(.ENTRIES(N)) dut (
        .clk (clk),
        .rst (rst),
        .bp  (bus)
    );

    always #5 clk = ~clk;

    // Reference model: plain per-entry arrays and a remaining-busy-cycles count.
    bit          m_valid [N];
    logic [31:0] m_tag   [N];
    logic [31:0] m_tgt   [N];
    int          m_ctr   [N];
    int          busy_left;
    logic        e_pv, e_pt, e_mp, e_busy;
    logic [31:0] e_ppc, e_ptg, e_rd, e_br, e_mpc;

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        busy_left = 0;
        e_pv = 0; e_pt = 0; e_mp = 0; e_busy = 0;
        e_ppc = '0; e_ptg = '0; e_rd = '0; e_br = '0; e_mpc = '0;
    endfunction

    function automatic void model_step();
        logic [31:0] fpc = bus.fetchPC;
        logic [31:0] rpc = bus.resolvePC;
        int unsigned fi  = (fpc >> 2) % N;
        int unsigned ri  = (rpc >> 2) % N;
        logic [31:0] ft  = fpc >> (IW + 2);
        logic [31:0] rt  = rpc >> (IW + 2);
        bit busy = (busy_left > 0);
        bit act  = bus.resolveIsBranch && bus.resolveTaken;
        bit rhit = m_valid[ri] && (m_tag[ri] == rt);
        bit tk;
        if (bus.fetchValid) begin
            tk = !busy && m_valid[fi] && (m_tag[fi] == ft) && (m_ctr[fi] >= 2);
            e_pv = 1; e_ppc = fpc; e_pt = tk;
            e_ptg = tk ? m_tgt[fi] : fpc + 32'd4;
        end else begin
            e_pv = 0;
        end
        if (bus.resolveValid && ((act != bus.resolvePredTaken) ||
                                 (act && bus.resolveTarget != bus.resolvePredTarget))) begin
            e_mp = 1;
            e_rd = act ? bus.resolveTarget : rpc + 32'd4;
            e_mpc = e_mpc + 1;
        end else begin
            e_mp = 0;
        end
        if (bus.resolveValid && bus.resolveIsBranch) e_br = e_br + 1;
        if (bus.resolveValid && !busy) begin
            if (bus.resolveIsBranch) begin
                if (rhit) begin
                    m_ctr[ri] = bus.resolveTaken ? ((m_ctr[ri] < 3) ? m_ctr[ri] + 1 : 3)
                                                 : ((m_ctr[ri] > 0) ? m_ctr[ri] - 1 : 0);
                    if (bus.resolveTaken) m_tgt[ri] = bus.resolveTarget;
                end else if (bus.resolveTaken) begin
                    m_valid[ri] = 1; m_tag[ri] = rt; m_tgt[ri] = bus.resolveTarget; m_ctr[ri] = 2;
                end
            end else if (rhit) begin
                m_valid[ri] = 0;
            end
        end
        if (busy) begin
            m_valid[N - busy_left] = 0;
            m_ctr[N - busy_left] = 1;
            busy_left--;
        end
        if (bus.flush) busy_left = N;
        e_busy = (busy_left > 0);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst) model_step();
        #1;
    endtask

    task automatic drive_idle();
        bus.fetchValid = 0; bus.fetchPC = '0;
        bus.resolveValid = 0; bus.resolveIsBranch = 0; bus.resolvePC = '0;
        bus.resolveTaken = 0; bus.resolveTarget = '0;
        bus.resolvePredTaken = 0; bus.resolvePredTarget = '0;
        bus.flush = 0;
    endtask

    task automatic drive_fetch(input logic [31:0] pc);
        bus.fetchValid = 1; bus.fetchPC = pc;
    endtask

    task automatic drive_resolve(input logic [31:0] pc, input logic br, input logic tk,
                                 input logic [31:0] tgt, input logic ptk, input logic [31:0] ptgt);
        bus.resolveValid = 1; bus.resolveIsBranch = br; bus.resolvePC = pc;
        bus.resolveTaken = tk; bus.resolveTarget = tgt;
        bus.resolvePredTaken = ptk; bus.resolvePredTarget = ptgt;
    endtask

    task automatic test_reset();
        drive_idle();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.predValid, bus.predPC, bus.predTaken, bus.predTarget, bus.mispredict,
             bus.redirectPC, bus.flushBusy} !== '0) begin
            failures++; $display("FAIL reset_outputs got nonzero predValid=%0b predTaken=%0b busy=%0b",
                                 bus.predValid, bus.predTaken, bus.flushBusy);
        end
        model_reset();
        rst = 1'b1;
    endtask

    task automatic test_basic();
        drive_idle(); drive_fetch(32'h100); tick();
        checks++; if (bus.predValid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%0b exp=1", bus.predValid); end
        checks++; if (bus.predPC !== 32'h100) begin failures++; $display("FAIL basic_pc got=%h exp=00000100", bus.predPC); end
        checks++; if (bus.predTaken !== 1'b0) begin failures++; $display("FAIL basic_taken got=%0b exp=0", bus.predTaken); end
        checks++; if (bus.predTarget !== 32'h104) begin failures++; $display("FAIL basic_target got=%h exp=00000104", bus.predTarget); end
        drive_idle(); tick();
        checks++; if (bus.predValid !== 1'b0 || bus.predTarget !== 32'h104) begin
            failures++; $display("FAIL basic_hold got valid=%0b target=%h exp valid=0 target=00000104", bus.predValid, bus.predTarget); end
    endtask

    task automatic test_train();
        drive_idle(); drive_resolve(32'h100, 1, 1, 32'h40, 0, 32'h104); tick();
        checks++; if (bus.mispredict !== 1'b1 || bus.redirectPC !== 32'h40) begin
            failures++; $display("FAIL train_mispredict got mp=%0b rd=%h exp mp=1 rd=00000040", bus.mispredict, bus.redirectPC); end
        drive_idle(); tick();
        checks++; if (bus.mispredict !== 1'b0) begin failures++; $display("FAIL train_pulse got=%0b exp=0", bus.mispredict); end
        drive_fetch(32'h100); tick();
        checks++; if (bus.predTaken !== 1'b1 || bus.predTarget !== 32'h40) begin
            failures++; $display("FAIL train_predict got tk=%0b tgt=%h exp tk=1 tgt=00000040", bus.predTaken, bus.predTarget); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            drive_idle(); drive_resolve(32'h100, 1, 1, 32'h40, 1, 32'h40); tick();
            checks++; if (bus.mispredict !== 1'b0) begin failures++; $display("FAIL sat_correct%0d got=%0b exp=0", i, bus.mispredict); end
        end
        drive_idle(); drive_resolve(32'h100, 1, 0, 32'h40, 1, 32'h40); tick();
        checks++; if (bus.mispredict !== 1'b1 || bus.redirectPC !== 32'h104) begin
            failures++; $display("FAIL sat_nt_redirect got mp=%0b rd=%h exp mp=1 rd=00000104", bus.mispredict, bus.redirectPC); end
        drive_idle(); drive_fetch(32'h100); tick();
        checks++; if (bus.predTaken !== 1'b1) begin failures++; $display("FAIL sat_first_nt got=%0b exp=1", bus.predTaken); end
        // Same-cycle read sees the counter before this resolve decrements it.
        drive_resolve(32'h100, 1, 0, 32'h40, 1, 32'h40); tick();
        checks++; if (bus.predTaken !== 1'b1) begin failures++; $display("FAIL sat_read_before_write got=%0b exp=1", bus.predTaken); end
        drive_idle(); drive_fetch(32'h100); tick();
        checks++; if (bus.predTaken !== 1'b0 || bus.predTarget !== 32'h104) begin
            failures++; $display("FAIL sat_second_nt got tk=%0b tgt=%h exp tk=0 tgt=00000104", bus.predTaken, bus.predTarget); end
    endtask

    task automatic test_alias();
        for (int i = 0; i < 2; i++) begin
            drive_idle(); drive_resolve(32'h100, 1, 1, 32'h40, 0, 32'h104); tick();
        end
        drive_idle(); drive_fetch(32'h140); tick();
        checks++; if (bus.predTaken !== 1'b0 || bus.predTarget !== 32'h144) begin
            failures++; $display("FAIL alias_miss got tk=%0b tgt=%h exp tk=0 tgt=00000144", bus.predTaken, bus.predTarget); end
        drive_fetch(32'h100); tick();
        checks++; if (bus.predTaken !== 1'b1) begin failures++; $display("FAIL alias_hit got=%0b exp=1", bus.predTaken); end
        drive_idle(); drive_resolve(32'h100, 0, 0, 32'h0, 0, 32'h104); tick();
        checks++; if (bus.mispredict !== 1'b0) begin failures++; $display("FAIL alias_nonbranch_mp got=%0b exp=0", bus.mispredict); end
        drive_idle(); drive_fetch(32'h100); tick();
        checks++; if (bus.predTaken !== 1'b0 || bus.predTarget !== 32'h104) begin
            failures++; $display("FAIL alias_invalidated got tk=%0b tgt=%h exp tk=0 tgt=00000104", bus.predTaken, bus.predTarget); end
    endtask

    task automatic test_flush();
        int n;
        bit nt_ok;
        for (int pass = 0; pass < 2; pass++) begin
            drive_idle(); drive_resolve(32'h100, 1, 1, 32'h40, 0, 32'h104); tick();
            drive_idle(); bus.flush = 1; tick();
            n = 0; nt_ok = 1;
            while (bus.flushBusy === 1'b1 && n < 100) begin
                n++;
                drive_idle(); drive_fetch(32'h100);
                bus.flush = (pass == 1 && n == 5);
                tick();
                if (bus.predTaken !== 1'b0) nt_ok = 0;
            end
            checks++; if (n != ((pass == 0) ? 16 : 21)) begin
                failures++; $display("FAIL flush_busy_len%0d got=%0d exp=%0d", pass, n, (pass == 0) ? 16 : 21); end
            checks++; if (!nt_ok) begin failures++; $display("FAIL flush_forced_nt%0d got=taken exp=not-taken", pass); end
            drive_idle(); drive_fetch(32'h100); tick();
            checks++; if (bus.predTaken !== 1'b0 || bus.predTarget !== 32'h104) begin
                failures++; $display("FAIL flush_cleared%0d got tk=%0b tgt=%h exp tk=0 tgt=00000104", pass, bus.predTaken, bus.predTarget); end
        end
    endtask

    task automatic test_wrap();
        drive_idle(); drive_fetch(32'hFFFF_FFFC);
        drive_resolve(32'hFFFF_FFFC, 1, 0, 32'h1234, 1, 32'h1234); tick();
        checks++; if (bus.mispredict !== 1'b1 || bus.redirectPC !== 32'h0) begin
            failures++; $display("FAIL wrap_redirect got mp=%0b rd=%h exp mp=1 rd=00000000", bus.mispredict, bus.redirectPC); end
        checks++; if (bus.predTarget !== 32'h0 || bus.predTaken !== 1'b0) begin
            failures++; $display("FAIL wrap_predict got tk=%0b tgt=%h exp tk=0 tgt=00000000", bus.predTaken, bus.predTarget); end
    endtask

    task automatic test_random();
        logic [31:0] pool [8];
        logic [31:0] tg [4];
        pool = '{32'h100, 32'h140, 32'h180, 32'h104, 32'h144, 32'hFFFF_FFFC, 32'h8000_0040, 32'h1C0};
        tg   = '{32'h40, 32'h200, 32'h0, 32'hABCD_0010};
        for (int i = 0; i < 400; i++) begin
            bus.fetchValid = ($urandom_range(0, 3) != 0);
            bus.fetchPC = pool[$urandom_range(0, 7)];
            bus.resolveValid = ($urandom_range(0, 2) != 0);
            bus.resolveIsBranch = ($urandom_range(0, 4) != 0);
            bus.resolvePC = pool[$urandom_range(0, 7)];
            bus.resolveTaken = $urandom_range(0, 1);
            bus.resolveTarget = tg[$urandom_range(0, 3)];
            bus.resolvePredTaken = $urandom_range(0, 1);
            bus.resolvePredTarget = tg[$urandom_range(0, 3)];
            bus.flush = ($urandom_range(0, 59) == 0);
            tick();
            checks++; if (bus.predValid !== e_pv) begin failures++; $display("FAIL rnd_predValid c%0d got=%0b exp=%0b", i, bus.predValid, e_pv); end
            checks++; if (bus.predPC !== e_ppc) begin failures++; $display("FAIL rnd_predPC c%0d got=%h exp=%h", i, bus.predPC, e_ppc); end
            checks++; if (bus.predTaken !== e_pt) begin failures++; $display("FAIL rnd_predTaken c%0d got=%0b exp=%0b", i, bus.predTaken, e_pt); end
            checks++; if (bus.predTarget !== e_ptg) begin failures++; $display("FAIL rnd_predTarget c%0d got=%h exp=%h", i, bus.predTarget, e_ptg); end
            checks++; if (bus.mispredict !== e_mp) begin failures++; $display("FAIL rnd_mispredict c%0d got=%0b exp=%0b", i, bus.mispredict, e_mp); end
            checks++; if (bus.redirectPC !== e_rd) begin failures++; $display("FAIL rnd_redirect c%0d got=%h exp=%h", i, bus.redirectPC, e_rd); end
            checks++; if (bus.flushBusy !== e_busy) begin failures++; $display("FAIL rnd_flushBusy c%0d got=%0b exp=%0b", i, bus.flushBusy, e_busy); end
`ifdef BRANCH_PREDICTOR_STATS_EN
            checks++; if (bus.statBranches !== e_br) begin failures++; $display("FAIL rnd_statBranches c%0d got=%0d exp=%0d", i, bus.statBranches, e_br); end
            checks++; if (bus.statMispredicts !== e_mpc) begin failures++; $display("FAIL rnd_statMispredicts c%0d got=%0d exp=%0d", i, bus.statMispredicts, e_mpc); end
`endif
        end
    endtask

    task automatic test_reset_midflush();
        drive_idle(); bus.flush = 1; tick();
        drive_idle(); repeat (3) tick();
        checks++; if (bus.flushBusy !== 1'b1) begin failures++; $display("FAIL midflush_busy got=%0b exp=1", bus.flushBusy); end
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.predValid, bus.predPC, bus.predTaken, bus.predTarget, bus.mispredict,
             bus.redirectPC, bus.flushBusy} !== '0) begin
            failures++; $display("FAIL midflush_reset_outputs got busy=%0b predValid=%0b exp all zero", bus.flushBusy, bus.predValid);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_fetch(32'h100); tick();
        checks++; if (bus.predTaken !== 1'b0 || bus.predTarget !== 32'h104 || bus.flushBusy !== 1'b0) begin
            failures++; $display("FAIL midflush_after got tk=%0b tgt=%h busy=%0b exp tk=0 tgt=00000104 busy=0",
                                 bus.predTaken, bus.predTarget, bus.flushBusy); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_train();
        test_saturation();
        test_alias();
        test_flush();
        test_wrap();
        test_random();
        test_reset_midflush();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised successor to the current branch/jump resolution logic: a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Sits beside the PC module. Receives the fetch PC, returns a registered taken/target prediction one cycle later.
- Accepts branch resolution from execute; on a wrong prediction it issues a registered mispredict plus redirect PC.
- Provides a multi-cycle flush sequencer for context switches and self-modifying code.

Parameters:
- ENTRIES, 16, number of BTB entries; power of two, >= 2.
- INDEX_W, $clog2(ENTRIES), index width (localparam, derived).
- TAG_W, 30-INDEX_W, tag width (localparam, derived).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- fetchValid  input  1  fetch PC is valid this cycle.
- fetchPC  input  32  fetch address; word aligned.
- predValid  output  1  registered: fetchValid delayed one cycle.
- predPC  output  32  registered copy of fetchPC.
- predTaken  output  1  prediction is taken.
- predTarget  output  32  predicted next PC.
- resolveValid  input  1  a resolved instruction is presented.
- resolveIsBranch  input  1  instruction is a branch or jump.
- resolvePC  input  32  address of the resolved instruction.
- resolveTaken  input  1  actual direction.
- resolveTarget  input  32  actual target when taken.
- resolvePredTaken  input  1  prediction that was used for this instruction.
- resolvePredTarget  input  32  target that was predicted for it.
- flush  input  1  single-cycle pulse: invalidate all entries.
- flushBusy  output  1  flush sequencer active.
- mispredict  output  1  registered, one-cycle pulse.
- redirectPC  output  32  registered correct next PC; valid only with mispredict.

Behaviour:
- Address split: index = PC[INDEX_W+1:2]; tag = PC[31:INDEX_W+2]. PC[1:0] is ignored.
- Entry contents: valid, tag, target[31:0], ctr[1:0].
- Counter encoding: 0 StrongNT, 1 WeakNT, 2 WeakT, 3 StrongT.
- Reset (rst low, asynchronous):
  - every entry valid=0, ctr=WeakNT.
  - flush FSM in IDLE.
  - all outputs 0.
- Prediction latency is 1 cycle. At the clock edge with fetchValid high:
  - predValid=1 and predPC=fetchPC.
  - hit = valid && tag match.
  - predTaken = hit && ctr[1].
  - predTarget = the entry target if predTaken, otherwise fetchPC+4 (modulo 2^32, so 0xFFFFFFFC gives 0x00000000).
  - fetchValid low gives predValid=0; the other prediction outputs hold.
- Update, when resolveValid && resolveIsBranch, in the FSM's IDLE state:
  - Hit: ctr increments on taken, saturating at 3; decrements on not-taken, saturating at 0. Target is overwritten when taken.
  - Miss and taken: allocate (overwrite) with valid=1, new tag, target=resolveTarget, ctr=WeakT.
  - Miss and not-taken: no write.
- Non-branch resolved with hit (aliasing): the entry is invalidated.
- Mispredict, registered one cycle after resolveValid:
  - Asserted when resolveTaken != resolvePredTaken, or when resolveTaken && resolveTarget != resolvePredTarget.
  - A non-branch is treated as resolveTaken=0.
  - redirectPC = resolveTarget if taken, else resolvePC+4 (wraps).
  - Otherwise mispredict=0.
- Same-cycle fetch read and resolve write to the same index: the read returns pre-write contents.
- Flush FSM:
  - States IDLE and CLEARING, with a clearIdx counter of INDEX_W bits.
  - flush in IDLE moves to CLEARING with clearIdx=0.
  - Each CLEARING cycle clears valid[clearIdx] and sets its ctr to WeakNT, then increments clearIdx.
  - After clearing index ENTRIES-1 the FSM returns to IDLE.
  - flushBusy = (state==CLEARING). The whole flush takes exactly ENTRIES cycles.
  - flush asserted during CLEARING restarts at clearIdx=0.
- During CLEARING:
  - all predictions are not-taken (predTarget=PC+4), though predValid still tracks fetchValid.
  - table updates are dropped.
  - mispredict/redirect are still computed and issued.
- Reset mid-flush: the table is fully cleared asynchronously and the FSM returns to IDLE.

Optional Feature:
- BRANCH_PREDICTOR_STATS_EN defined:
  - adds outputs statBranches[31:0] (count of resolved branches) and statMispredicts[31:0] (count of mispredict pulses).
  - both counters wrap at 2^32, reset to 0, and are not cleared by flush.
- Undefined: these ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- BranchPredictorPackage holds:
  - enum BtbCounter (values 0..3 as above).
  - enum FlushState {FlushState_IDLE, FlushState_CLEARING}.
  - packed struct BtbEntry {valid, tag, target, ctr}, with the tag width fixed at package maximum and sliced in the module.
  - function nextCounter(ctr, taken), which saturates.
- Sub-module branch_target_buffer: the entry array with one read port and one write port (read-before-write), plus a per-index clear port for the flush sequencer. Prediction, update decision, mispredict and the FSM stay in branch_predictor.

Test Plan:
- Reset, then fetchPC=0x00000100 → next cycle predValid=1, predTaken=0, predTarget=0x00000104.
- Resolve PC=0x100 taken to 0x40 with predTaken=0 → next cycle mispredict=1, redirectPC=0x40. A later fetch of 0x100 → predTaken=1, predTarget=0x40.
- Counter saturation: three resolves of 0x100 taken; first not-taken resolve keeps predTaken=1 (ctr=2); second not-taken gives predTaken=0.
- Alias with ENTRIES=16: entry for 0x100 is trained; fetch of 0x140 (same index, different tag) → predTaken=0, predTarget=0x144. A non-branch resolve of 0x100 invalidates the entry.
- flush pulse → flushBusy high for exactly 16 cycles, predictions forced not-taken; afterwards fetch 0x100 misses. A second flush at cycle 5 extends busy to 21 cycles.
- Wrap: resolve PC=0xFFFFFFFC, resolvePredTaken=1, actually not-taken → mispredict=1, redirectPC=0x00000000. Asserting rst low mid-flush → flushBusy=0 and all outputs 0 immediately.
